// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported word memory between the
// instruction-fetch (imem) and data (dmem) request ports.
// - One grant per cycle, decided combinationally in the request cycle.
// - The read or write response comes back one cycle after the accept, and is
//   routed to the port that won.
// - Default build: dmem has fixed priority, and a starvation guard force-grants
//   imem after STARVE_MAX consecutive denials.
// - Optional macro MEM_ARB_RR_EN: ties alternate round-robin instead, and the
//   starvation guard is not built.
// - conflict_count is a saturating count of cycles in which both ports request.
module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imemreq_val,
  output logic             imemreq_rdy,
  input  logic [31:0]      imemreq_addr,
  output logic             imemresp_val,
  output logic [31:0]      imemresp_data,
  input  logic             dmemreq_val,
  output logic             dmemreq_rdy,
  input  logic             dmemreq_type,
  input  logic [31:0]      dmemreq_addr,
  input  logic [31:0]      dmemreq_wdata,
  output logic             dmemresp_val,
  output logic [31:0]      dmemresp_rdata,
  output logic             memreq_val,
  output logic             memreq_type,
  output logic [31:0]      memreq_addr,
  output logic [31:0]      memreq_wdata,
  input  logic [31:0]      memresp_rdata,
  output logic [CNT_W-1:0] conflict_count
);

  // Owner of the response arriving next cycle; a dmem write needs no read data.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_DRD  = 2'd2,
    OWN_DWR  = 2'd3
  } owner_e;

  owner_e           owner_q, owner_d;
  logic [CNT_W-1:0] conflict_q, conflict_d;
  logic             grant_i_s, grant_d_s;
  logic             both_s;

  assign both_s = imemreq_val & dmemreq_val;

`ifdef MEM_ARB_RR_EN
  // 1 when the most recent grant went to imem; the reset value means dmem.
  logic last_grant_i_q, last_grant_i_d;
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  logic [3:0] starve_q, starve_d;
`endif

  // Pick the winner of this cycle from the live request valids.
  always_comb begin
    grant_i_s = 1'b0;
    grant_d_s = 1'b0;
    if (both_s) begin
`ifdef MEM_ARB_RR_EN
      if (last_grant_i_q) begin
        grant_d_s = 1'b1;
      end else begin
        grant_i_s = 1'b1;
      end
`else
      if (starve_q == STARVE_LIM) begin
        grant_i_s = 1'b1;
      end else begin
        grant_d_s = 1'b1;
      end
`endif
    end else if (imemreq_val) begin
      grant_i_s = 1'b1;
    end else if (dmemreq_val) begin
      grant_d_s = 1'b1;
    end else begin
      grant_i_s = 1'b0;
      grant_d_s = 1'b0;
    end
  end

  assign imemreq_rdy = grant_i_s;
  assign dmemreq_rdy = grant_d_s;

  // Steer the winner onto the shared memory port; drive zeros when nobody wins.
  always_comb begin
    memreq_val   = 1'b0;
    memreq_type  = 1'b0;
    memreq_addr  = 32'h0000_0000;
    memreq_wdata = 32'h0000_0000;
    if (grant_i_s) begin
      memreq_val   = 1'b1;
      memreq_type  = 1'b0;
      memreq_addr  = imemreq_addr;
      memreq_wdata = 32'h0000_0000;
    end else if (grant_d_s) begin
      memreq_val   = 1'b1;
      memreq_type  = dmemreq_type;
      memreq_addr  = dmemreq_addr;
      memreq_wdata = dmemreq_wdata;
    end else begin
      memreq_val   = 1'b0;
      memreq_type  = 1'b0;
      memreq_addr  = 32'h0000_0000;
      memreq_wdata = 32'h0000_0000;
    end
  end

  // Next-state values for the response owner and the contention counter.
  always_comb begin
    owner_d    = OWN_NONE;
    conflict_d = conflict_q;
    if (grant_i_s) begin
      owner_d = OWN_I;
    end else if (grant_d_s) begin
      owner_d = dmemreq_type ? OWN_DWR : OWN_DRD;
    end else begin
      owner_d = OWN_NONE;
    end
    if (both_s && (conflict_q != {CNT_W{1'b1}})) begin
      conflict_d = conflict_q + CNT_W'(1);
    end else begin
      conflict_d = conflict_q;
    end
  end

  // Owner and contention state; reset drops any in-flight response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q    <= OWN_NONE;
      conflict_q <= {CNT_W{1'b0}};
    end else begin
      owner_q    <= owner_d;
      conflict_q <= conflict_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Remember who was granted last, so that the next tie goes to the other port.
  always_comb begin
    last_grant_i_d = last_grant_i_q;
    if (grant_i_s) begin
      last_grant_i_d = 1'b1;
    end else if (grant_d_s) begin
      last_grant_i_d = 1'b0;
    end else begin
      last_grant_i_d = last_grant_i_q;
    end
  end

  // Round-robin history register; after reset the last grant counts as dmem.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_i_q <= 1'b0;
    end else begin
      last_grant_i_q <= last_grant_i_d;
    end
  end
`else
  // Count consecutive imem denials, saturating at the force-grant threshold.
  always_comb begin
    starve_d = starve_q;
    if (!imemreq_val || grant_i_s) begin
      starve_d = 4'd0;
    end else if (starve_q < STARVE_LIM) begin
      starve_d = starve_q + 4'd1;
    end else begin
      starve_d = starve_q;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`endif

  // Route the single-cycle memory response to whichever port owns it.
  always_comb begin
    imemresp_val   = 1'b0;
    imemresp_data  = 32'h0000_0000;
    dmemresp_val   = 1'b0;
    dmemresp_rdata = 32'h0000_0000;
    case (owner_q)
      OWN_I: begin
        imemresp_val  = 1'b1;
        imemresp_data = memresp_rdata;
      end
      OWN_DRD: begin
        dmemresp_val   = 1'b1;
        dmemresp_rdata = memresp_rdata;
      end
      OWN_DWR: begin
        dmemresp_val   = 1'b1;
        dmemresp_rdata = 32'h0000_0000;
      end
      default: begin
        imemresp_val   = 1'b0;
        imemresp_data  = 32'h0000_0000;
        dmemresp_val   = 1'b0;
        dmemresp_rdata = 32'h0000_0000;
      end
    endcase
  end

  assign conflict_count = conflict_q;

endmodule
